// File: rtl/alu_pkg.sv
// Shared ALU command types: the command record fed to the ALU, plus the
// issue-stage state encoding used by alu_cmd_issue.
package alu_pkg;

    localparam int OPCODE_W  = 3;
    localparam int OPERAND_W = 4;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [OPERAND_W-1:0] op1;
        logic [OPERAND_W-1:0] op2;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HELD  = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of ALU commands. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter; the head
// entry is visible combinationally so the issue stage can load it directly.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  alu_cmd_t      i_data,
    output alu_cmd_t      o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    alu_cmd_t    r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] w_diff;

    // Pointer update; flush returns both pointers to zero and blocks push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign w_diff  = r_wr_ptr - r_rd_ptr;
    assign o_level = LW'(w_diff);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/alu_cmd_issue.sv
// Command feeder for the 4-bit ALU: buffers commands in a FIFO and issues
// one per cycle from a registered stage, with stall and synchronous flush.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_EMPTY | nothing issued this cycle, issue_valid = 0, outputs hold
//   ST_ISSUE | head popped into OPCODE/OP1/OP2 this cycle, issue_valid = 1
//   ST_HELD  | stall active, outputs and issue_valid frozen
module alu_cmd_issue
    import alu_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int CNT_W = 8,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPCODE_W-1:0]  in_opcode,
    input  logic [OPERAND_W-1:0] in_op1,
    input  logic [OPERAND_W-1:0] in_op2,
    input  logic                 stall,
    input  logic                 flush,
    output logic [OPCODE_W-1:0]  OPCODE,
    output logic [OPERAND_W-1:0] OP1,
    output logic [OPERAND_W-1:0] OP2,
    output logic                 issue_valid,
    output logic [LW-1:0]        level,
    output logic [CNT_W-1:0]     issued_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    issue_state_t     r_state, w_state_nxt;
    alu_cmd_t         r_cmd, w_cmd_nxt;
    logic             r_issue_valid, w_issue_valid_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    alu_cmd_t w_in_cmd;
    alu_cmd_t w_head;
    logic     w_full;
    logic     w_empty;
    logic     w_push;
    logic     w_pop;

    // in_ready depends only on registered FIFO state and flush, never in_valid.
    assign in_ready = ~w_full & ~flush;
    assign w_push   = in_valid & in_ready;
    assign w_pop    = ~flush & ~stall & ~w_empty;
    assign w_in_cmd = '{opcode: in_opcode, op1: in_op1, op2: in_op2};

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_data  (w_in_cmd),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    // Issue priority: flush, then stall, then pop if data, else go idle.
    always_comb begin
        w_state_nxt       = r_state;
        w_cmd_nxt         = r_cmd;
        w_issue_valid_nxt = r_issue_valid;
        w_cnt_nxt         = r_cnt;
        if (flush) begin
            w_state_nxt       = ST_EMPTY;
            w_issue_valid_nxt = 1'b0;
        end else if (stall) begin
            w_state_nxt = ST_HELD;
        end else if (!w_empty) begin
            w_state_nxt       = ST_ISSUE;
            w_cmd_nxt         = w_head;
            w_issue_valid_nxt = 1'b1;
            w_cnt_nxt         = r_cnt + CNT_ONE;
        end else begin
            w_state_nxt       = ST_EMPTY;
            w_issue_valid_nxt = 1'b0;
        end
    end

    // Issue-stage registers: state, ALU-facing command, valid flag, counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_EMPTY;
            r_cmd         <= '0;
            r_issue_valid <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmd         <= w_cmd_nxt;
            r_issue_valid <= w_issue_valid_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign OPCODE      = r_cmd.opcode;
    assign OP1         = r_cmd.op1;
    assign OP2         = r_cmd.op2;
    assign issue_valid = r_issue_valid;
    assign issued_cnt  = r_cnt;

endmodule
